// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M muldiv sequencer.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, a, b, kill,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, funct3, a, b, kill,
    output busy, stall, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, registered result.
// Optional MULDIV_FAST_SPECIAL_EN: trivial div/rem/mul cases finish in 1 cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state, w_state_n;
  logic [2:0]        r_f3;
  logic              r_sa, r_sb;
  logic [XLEN-1:0]   r_ma, r_mb, r_result;
  logic [2*XLEN-1:0] r_acc, w_acc_n;
  logic [CW-1:0]     r_cnt;

  logic              w_accept, w_fast, w_in_sa, w_in_sb;
  logic [XLEN-1:0]   w_in_ma, w_in_mb;
  logic [XLEN:0]     w_rsh;
  logic [XLEN-1:0]   w_sub;

  function automatic logic [XLEN-1:0] f_result(
    input logic [2:0]        f3,
    input logic              sa,
    input logic              sb,
    input logic [XLEN-1:0]   ma,
    input logic [XLEN-1:0]   mb,
    input logic [2*XLEN-1:0] acc
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q, r, av;
    logic              div0, ovf;
    prod = (sa ^ sb) ? (~acc + 1'b1) : acc;
    q    = (sa ^ sb) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    r    = sa ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    av   = sa ? (~ma + 1'b1) : ma;
    div0 = (mb == '0);
    ovf  = sa && sb && (ma == MIN) && (mb == XLEN'(1));
    case (f3)
      3'b000:  f_result = prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  f_result = prod[2*XLEN-1:XLEN];
      3'b100,
      3'b101:  f_result = div0 ? '1 : (ovf ? MIN : q);
      default: f_result = div0 ? av : (ovf ? '0 : r);
    endcase
  endfunction

  // a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM
  assign w_in_sa = bus.a[XLEN-1] &&
                   (bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
  assign w_in_sb = bus.b[XLEN-1] &&
                   (bus.funct3 inside {3'b001, 3'b100, 3'b110});
  assign w_in_ma = w_in_sa ? (~bus.a + 1'b1) : bus.a;
  assign w_in_mb = w_in_sb ? (~bus.b + 1'b1) : bus.b;

  assign w_accept = bus.start && !bus.kill && (r_state != S_CALC);

`ifdef MULDIV_FAST_SPECIAL_EN
  assign w_fast = bus.funct3[2]
    ? ((w_in_mb == '0) ||
       (w_in_sa && w_in_sb && (w_in_ma == MIN) && (w_in_mb == XLEN'(1))))
    : ((w_in_ma == '0) || (w_in_mb == '0));
`else
  assign w_fast = 1'b0;
`endif

  assign w_rsh = {r_acc[2*XLEN-1:XLEN], r_ma[r_cnt]};
  assign w_sub = w_rsh[XLEN-1:0] - r_mb;

  always_comb begin
    w_acc_n = r_acc;
    if (r_f3[2]) begin
      if (w_rsh >= {1'b0, r_mb})
        w_acc_n = {w_sub, r_acc[XLEN-2:0], 1'b1};
      else
        w_acc_n = {w_rsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end else begin
      w_acc_n = {r_acc[2*XLEN-2:0], 1'b0} +
                (r_mb[r_cnt] ? {{XLEN{1'b0}}, r_ma} : '0);
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (bus.kill && (r_state != S_IDLE)) begin
      w_state_n = S_IDLE;
    end else begin
      case (r_state)
        S_CALC:  if (r_cnt == '0) w_state_n = S_DONE;
        default: begin
          if (w_accept) w_state_n = w_fast ? S_DONE : S_CALC;
          else          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f3     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_f3  <= bus.funct3;
      r_sa  <= w_in_sa;
      r_sb  <= w_in_sb;
      r_ma  <= w_in_ma;
      r_mb  <= w_in_mb;
      r_acc <= '0;
      r_cnt <= CW'(XLEN-1);
      if (w_fast)
        r_result <= f_result(bus.funct3, w_in_sa, w_in_sb,
                             w_in_ma, w_in_mb, '0);
    end else if ((r_state == S_CALC) && !bus.kill) begin
      r_acc <= w_acc_n;
      if (r_cnt == '0)
        r_result <= f_result(r_f3, r_sa, r_sb, r_ma, r_mb, w_acc_n);
      else
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bus.busy   = (r_state == S_CALC);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
  assign bus.stall  = bus.busy ||
                      (bus.start && (r_state != S_CALC) && !bus.kill);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010;
  localparam logic [2:0] MULHU = 3'b011, DIV = 3'b100, DIVU = 3'b101;
  localparam logic [2:0] REM = 3'b110;
`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 33;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns just after the accepting posedge
  task automatic go(input string tag, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    #1 chk({tag, "_stall_req"}, 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.a      = $urandom;
    bus.b      = $urandom;
  endtask

  task automatic wait_done(output int n, output int stl_lo);
    n = 0;
    stl_lo = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
      if (!bus.stall) stl_lo++;
    end
  endtask

  task automatic op(input string tag, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input int lat);
    int n, s;
    go(tag, f3, a, b);
    wait_done(n, s);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_stall"}, 32'(s), 32'd0);
  endtask

  initial begin
    int cnt;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = '0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    op("mul",    MUL,   32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    op("mulhu",  MULHU, 32'd7, 32'hFFFFFFFD, 32'h00000006, 33);
    op("mulh",   MULH,  32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    op("div",    DIV,   32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 33);
    op("rem",    REM,   32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 33);
    op("divu",   DIVU,  32'h80000000, 32'd2, 32'h40000000, 33);
    op("divu0",  DIVU,  32'h1234, 32'd0, 32'hFFFFFFFF, SPL);
    op("rem0",   REM,   32'h1234, 32'd0, 32'h00001234, SPL);
    op("divovf", DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPL);
    op("removf", REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPL);

    // second op is requested during the first op's done cycle
    op("b2b_mul",    MUL,    32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    op("b2b_mulhsu", MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
    @(negedge clk);
    chk("done_single", 32'(bus.done), 32'd0);
    chk("idle_stall", 32'(bus.stall), 32'd0);

    go("kill", DIV, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    chk("kill_busy_pre", 32'(bus.busy), 32'd1);
    bus.kill = 1'b1;
    @(posedge clk);
    #1 bus.kill = 1'b0;
    chk("kill_busy", 32'(bus.busy), 32'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    chk("kill_nodone", 32'(cnt), 32'd0);
    chk("kill_result", bus.result, 32'hFFFFFFFF);

    bus.start  = 1'b1;
    bus.kill   = 1'b1;
    bus.funct3 = MUL;
    bus.a      = 32'd3;
    bus.b      = 32'd3;
    #1 chk("killstart_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    chk("killstart_busy", 32'(bus.busy), 32'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    chk("killstart_nodone", 32'(cnt), 32'd0);

    go("arst", MUL, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    op("mul56", MUL, 32'd5, 32'd6, 32'd30, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
